load_store_unit: RTL
====================

# load_store_unit

Data-side memory access unit that sits directly downstream of the core's s2 (read/write memory) stage and upstream of the word-wide RAM. It takes one byte, half or word load/store request at a time and converts it into word-aligned memory transactions. Sub-word stores are done as read-modify-write, and load data is lane-extracted and zero- or sign-extended before being returned. This is where the core's byte/half truncation microcode bits (18–21) are realised.

## Interface
- No parameters; address 32 bits, data 32 bits, memory word address 30 bits (fixed).
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: core presents a request.
- `req_ready` out 1: unit can accept; high only in IDLE and while `rst`=0.
- `req_we` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 byte, 01 half, 10 word, 11 reserved.
- `req_unsigned` in 1: load zero-extends (LBU/LHU); ignored for stores and words.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-justified.
- `resp_valid` out 1: one-cycle pulse; request complete.
- `resp_data` out 32: extended load result; 0 for stores and faults.
- `resp_fault` out 1: misaligned or reserved-size request (see Configuration).
- `mem_req` out 1: memory transaction active.
- `mem_we` out 1: 1 = word write.
- `mem_addr` out 30: word address (`req_addr[31:2]`).
- `mem_wdata` out 32: full word to write.
- `mem_ack` in 1: transaction completes this cycle.
- `mem_rdata` in 32: read word, valid when `mem_ack`=1 and `mem_we`=0.

## Operation
- States: IDLE, READ, RMW_READ, WRITE, RESP.
- IDLE: `req_valid & req_ready` latches we/size/unsigned/addr/wdata.
  - Load goes to READ.
  - Word store goes to WRITE with `mem_wdata=req_wdata`.
  - Byte or half store goes to RMW_READ.
  - Fault goes to RESP.
- READ: `mem_req`=1, `mem_we`=0. On `mem_ack`, register the extracted result and go to RESP.
- RMW_READ: `mem_req`=1, `mem_we`=0. On `mem_ack`, merge the store data into `mem_rdata` and go to WRITE.
  - Byte store: lane `addr[1:0]` takes `wdata[7:0]`.
  - Half store: lane `addr[1]` takes `wdata[15:0]`.
  - All other bits are preserved.
- WRITE: `mem_req`=1, `mem_we`=1. On `mem_ack`, go to RESP.
- RESP: `resp_valid`=1 for exactly one cycle, then IDLE.
- Load extraction:
  - Byte = `rdata[8*addr[1:0] +: 8]`.
  - Half = `rdata[16*addr[1] +: 16]`.
  - Sign-extend from bit 7 or bit 15 unless `req_unsigned`.
- `mem_req` is held high until `mem_ack`. `mem_addr`, `mem_we` and `mem_wdata` are stable while `mem_req`=1.
- A new transaction may start in the cycle after an ack; RMW_READ→WRITE has no idle gap.
- `mem_ack` while `mem_req`=0 is ignored.
- Reset mid-operation: the next edge forces IDLE and clears all outputs. An in-flight memory transaction is abandoned, with `mem_req` low from that edge.

## Timing
- Reset values: `req_ready`=0 while `rst`=1. After reset, `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `resp_valid`=0, `resp_data`=0, `resp_fault`=0.
- Accept at edge 0; `mem_req` rises in cycle 1.
- Load or word store with ack in cycle k (k≥1): `resp_valid` in cycle k+1; next accept at earliest in cycle k+2.
- Sub-word store with read ack in cycle k and write ack in cycle j (j≥k+1): `resp_valid` in cycle j+1.
- Zero-wait memory (ack in the first request cycle): load/word store 3 cycles accept-to-accept; sub-word store 4 cycles.
- Fault: `resp_valid` in cycle 1, no memory activity.
- All outputs are registered.
- `resp_data` and `resp_fault` hold their value until the next `resp_valid`.

## Configuration
- `LSU_MISALIGN_FAULT_EN`
- Defined:
  - Fault conditions are half with `addr[0]`=1, word with `addr[1:0]`≠0, and `req_size`=11.
  - A faulting request goes directly to RESP with `resp_fault`=1 and `resp_data`=0; no `mem_req` is issued.
- Undefined:
  - `resp_fault` is tied to 0.
  - Half ignores `addr[0]`; word ignores `addr[1:0]`.
  - `req_size`=11 is treated as word.

## Test plan
- Word load, `addr`=0x10, memory word 4 = 0xDEADBEEF, ack after 2 wait cycles -> `mem_addr`=4; `resp_data`=0xDEADBEEF in the cycle after ack.
- Byte loads from 0x13 with word = 0x80FF7F01 -> signed gives 0xFFFFFF80; unsigned gives 0x00000080. Half signed load at 0x10 -> 0x00007F01.
- Byte store 0xAB to 0x21 over 0x11223344 -> read then write of 0x1122AB44 to word 8, with `mem_req` continuous between the two transactions; store `resp_data`=0.
- Word store back-to-back with zero-wait memory -> second request accepted exactly 3 cycles after the first; no request lost.
- Half load at 0x03 -> with the macro, `resp_fault`=1 in cycle 1 and `mem_req` never rises; without it, the lane selects `addr[1]`=1 and `resp_fault`=0.
- `rst` asserted in the WRITE state with ack withheld -> next cycle `mem_req`=0, `resp_valid`=0, `req_ready`=1 once `rst` drops.

Source files
------------

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - byte/half/word load-store unit with read-modify-write sub-word stores
// Optional misalignment/reserved-size faulting is enabled by defining LSU_MISALIGN_FAULT_EN.
module load_store_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic        resp_fault,
    output logic        mem_req,
    output logic        mem_we,
    output logic [29:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {IDLE, READ, RMW_READ, WRITE, RESP} state_t;

    state_t      state;
    logic [1:0]  size_q;
    logic        unsigned_q;
    logic [1:0]  lane_q;
    logic [31:0] wdata_q;
    logic        is_fault;

    always_comb begin
        is_fault = 1'b0;
`ifdef LSU_MISALIGN_FAULT_EN
        is_fault = (req_size == 2'b11)
                 | ((req_size == 2'b01) & req_addr[0])
                 | ((req_size == 2'b10) & (req_addr[1:0] != 2'b00));
`endif
    end

    assign req_ready = (state == IDLE) && !rst;

    // size[1] set means a full word (reserved size 11 behaves as word when not faulted).
    function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] size,
                                            input logic [1:0] lane, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        if (size[1])
            extract = word;
        else if (size[0])
            extract = {{16{h[15] & ~uns}}, h};
        else
            extract = {{24{b[7] & ~uns}}, b};
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] word, input logic [1:0] size,
                                          input logic [1:0] lane, input logic [31:0] wdata);
        merge = word;
        if (size[0]) begin
            if (lane[1]) merge[31:16] = wdata[15:0];
            else         merge[15:0]  = wdata[15:0];
        end else begin
            case (lane)
                2'd0:    merge[7:0]   = wdata[7:0];
                2'd1:    merge[15:8]  = wdata[7:0];
                2'd2:    merge[23:16] = wdata[7:0];
                default: merge[31:24] = wdata[7:0];
            endcase
        end
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            size_q     <= 2'b00;
            unsigned_q <= 1'b0;
            lane_q     <= 2'b00;
            wdata_q    <= 32'h0;
            resp_valid <= 1'b0;
            resp_data  <= 32'h0;
            resp_fault <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= 30'h0;
            mem_wdata  <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    resp_valid <= 1'b0;
                    if (req_valid) begin
                        size_q     <= req_size;
                        unsigned_q <= req_unsigned;
                        lane_q     <= req_addr[1:0];
                        wdata_q    <= req_wdata;
                        if (is_fault) begin
                            resp_valid <= 1'b1;
                            resp_fault <= 1'b1;
                            resp_data  <= 32'h0;
                            state      <= RESP;
                        end else begin
                            mem_addr <= req_addr[31:2];
                            mem_req  <= 1'b1;
                            if (!req_we) begin
                                mem_we <= 1'b0;
                                state  <= READ;
                            end else if (req_size[1]) begin
                                mem_we    <= 1'b1;
                                mem_wdata <= req_wdata;
                                state     <= WRITE;
                            end else begin
                                mem_we <= 1'b0;
                                state  <= RMW_READ;
                            end
                        end
                    end
                end
                READ: begin
                    if (mem_ack) begin
                        mem_req    <= 1'b0;
                        resp_data  <= extract(mem_rdata, size_q, lane_q, unsigned_q);
                        resp_fault <= 1'b0;
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end
                end
                RMW_READ: begin
                    // mem_req stays high so the write follows the read without a gap.
                    if (mem_ack) begin
                        mem_we    <= 1'b1;
                        mem_wdata <= merge(mem_rdata, size_q, lane_q, wdata_q);
                        state     <= WRITE;
                    end
                end
                WRITE: begin
                    if (mem_ack) begin
                        mem_req    <= 1'b0;
                        mem_we     <= 1'b0;
                        resp_data  <= 32'h0;
                        resp_fault <= 1'b0;
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    resp_valid <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
